// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame layout, opcodes and FSM state encodings.
// Used by both the MDIO master and the PHY-side receiver.
package mdio_pkg;

  localparam int FRAME_W = 32;
  localparam int DATA_W  = 16;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Field positions, MSB first: ST[31:30] OP[29:28] PHYADR[27:23] REGADR[22:18] TA[17:16] DATA[15:0]
  typedef struct packed {
    logic [1:0]        st;
    logic [1:0]        op;
    logic [4:0]        phyadr;
    logic [4:0]        regadr;
    logic [1:0]        ta;
    logic [DATA_W-1:0] data;
  } mdio_frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_WDAT,
    S_RDAT
  } mdio_state_e;

  function automatic logic frame_valid(input mdio_frame_t f);
    return (f.st == ST_CODE) && ((f.op == OP_WRITE) || (f.op == OP_READ));
  endfunction

endpackage

// File: rtl/mdio_gen_if.sv
// Host and PHY-side signals of the MDIO master, bundled for port connection.
interface mdio_gen_if;
  import mdio_pkg::*;

  logic               mdio_start;
  logic [FRAME_W-1:0] t_data;
  logic               mdio_in;
  logic               mdc;
  logic               mdio_oe;
  logic               mdio_out;
  logic [DATA_W-1:0]  rd_data;
  logic               data_rdy;
  logic               busy;

  modport master (
    input  mdio_start, t_data, mdio_in,
    output mdc, mdio_oe, mdio_out, rd_data, data_rdy, busy
  );

  modport slave (
    output mdio_start, t_data, mdio_in,
    input  mdc, mdio_oe, mdio_out, rd_data, data_rdy, busy
  );

endinterface

// File: rtl/mdio_gen_mdc.sv
// Free-running MDC divider. The event strobes are high in the cycle before the
// CLK edge on which MDC falls or rises, so logic clocked on that edge moves with MDC.
module mdc_gen
  import mdio_pkg::*;
#(
  parameter int MDC_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic mdc_o,
  output logic fall_evt_o,
  output logic rise_evt_o
);

  localparam int            CW   = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MDC_DIV - 1);

  logic [CW-1:0] div_q;
  logic          mdc_q;
  logic          tick;

  assign tick       = (div_q == LAST);
  assign fall_evt_o = tick & mdc_q;
  assign rise_evt_o = tick & ~mdc_q;
  assign mdc_o      = mdc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else if (tick) begin
      div_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      div_q <= div_q + CW'(1);
    end
  end

endmodule

// File: rtl/mdio_gen.sv
// Clause 22 MDIO master: shifts a latched frame out on MDC falls and, for reads,
// releases the line and shifts the PHY reply in on MDC rises.
module mdio_gen
  import mdio_pkg::*;
#(
  parameter int MDC_DIV = 1,
  parameter int PRE_LEN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  mdio_gen_if.master bus
);

  localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'd15;
  localparam logic [5:0] WDAT_END  = 6'd16;
  localparam logic [5:0] DATA_LAST = 6'd15;

  mdio_state_e        state_q;
  logic [5:0]         cnt_q;
  logic [FRAME_W-1:0] frame_q;
  logic               is_read_q;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  shift_d;
  logic [DATA_W-1:0]  rd_data_q;
  logic               oe_q;
  logic               out_q;
  logic               busy_q;
  logic               rdy_q;
  logic               fall_evt;
  logic               rise_evt;
  mdio_frame_t        req;

  mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdc_o      (bus.mdc),
    .fall_evt_o (fall_evt),
    .rise_evt_o (rise_evt)
  );

  assign req          = bus.t_data;
  assign shift_d      = {shift_q[DATA_W-2:0], bus.mdio_in};
  assign bus.mdio_oe  = oe_q;
  assign bus.mdio_out = out_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.data_rdy = rdy_q;
  assign bus.busy     = busy_q;

  // frame_q shifts left on every launched bit, so the next bit is always frame_q[31]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      is_read_q <= 1'b0;
      shift_q   <= '0;
      rd_data_q <= '0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.mdio_start && frame_valid(req)) begin
            frame_q   <= bus.t_data;
            is_read_q <= (req.op == OP_READ);
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= (PRE_LEN > 0) ? S_PRE : S_HDR;
          end
        end
        S_PRE: begin
          if (fall_evt) begin
            oe_q  <= 1'b1;
            out_q <= 1'b1;
            if (cnt_q == PRE_LAST) begin
              cnt_q   <= '0;
              state_q <= S_HDR;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        S_HDR: begin
          if (fall_evt) begin
            oe_q    <= 1'b1;
            out_q   <= frame_q[FRAME_W-1];
            frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
            if (cnt_q == HDR_LAST) begin
              cnt_q   <= '0;
              state_q <= is_read_q ? S_RDAT : S_WDAT;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        S_WDAT: begin
          if (fall_evt) begin
            if (cnt_q == WDAT_END) begin
              oe_q    <= 1'b0;
              out_q   <= 1'b0;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              oe_q    <= 1'b1;
              out_q   <= frame_q[FRAME_W-1];
              frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
              cnt_q   <= cnt_q + 6'd1;
            end
          end
        end
        S_RDAT: begin
          // First fall here releases the line; falls after that count samples taken
          if (fall_evt) begin
            if (oe_q) begin
              oe_q  <= 1'b0;
              out_q <= 1'b0;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end else if (rise_evt && !oe_q) begin
            shift_q <= shift_d;
            if (cnt_q == DATA_LAST) begin
              rd_data_q <= shift_d;
              rdy_q     <= 1'b1;
              busy_q    <= 1'b0;
              cnt_q     <= '0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_gen.sv
// Directed bench for mdio_gen: one instance at MDC_DIV=1/PRE_LEN=0 and one at
// MDC_DIV=4/PRE_LEN=32, with a cycle-level PHY model answering reads.
module tb_mdio_gen;
  import mdio_pkg::*;

  typedef struct {
    logic        sel;
    logic [31:0] tData;
    logic [15:0] reply;
    int          reStart;
    logic [31:0] reData;
    logic [63:0] expBits;
    int          expNBits;
    int          expRdy;
    logic [15:0] expRd;
    int          maxCycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        startR;
  logic [31:0] tDataR;
  logic        mdioIn;

  logic        mdcW, oeW, outW, busyW, rdyW;
  logic [15:0] rdDataW;

  int          checks;
  int          failures;
  logic [63:0] frameBits;
  int          nBits, oeCycles, busyCycles, rdyPulses, outHigh, mdcPeriod, postBusy;
  logic        timedOut, resetHit;
  logic [20:0] snap;
  logic [15:0] rdDataEnd;
  vec_t        vecs[8];

  always #5 clk = ~clk;

  mdio_gen_if bus0 ();
  mdio_gen_if bus1 ();

  assign bus0.mdio_start = startR & ~sel;
  assign bus1.mdio_start = startR & sel;
  assign bus0.t_data     = tDataR;
  assign bus1.t_data     = tDataR;
  assign bus0.mdio_in    = mdioIn;
  assign bus1.mdio_in    = mdioIn;

  mdio_gen #(.MDC_DIV(1), .PRE_LEN(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  mdio_gen #(.MDC_DIV(4), .PRE_LEN(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  assign mdcW    = sel ? bus1.mdc      : bus0.mdc;
  assign oeW     = sel ? bus1.mdio_oe  : bus0.mdio_oe;
  assign outW    = sel ? bus1.mdio_out : bus0.mdio_out;
  assign busyW   = sel ? bus1.busy     : bus0.busy;
  assign rdyW    = sel ? bus1.data_rdy : bus0.data_rdy;
  assign rdDataW = sel ? bus1.rd_data  : bus0.rd_data;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setVec(input int i, input logic s, input logic [31:0] td, input logic [15:0] rp,
                        input int rs, input logic [31:0] rd2, input logic [63:0] eb, input int en,
                        input int er, input logic [15:0] erd, input int mc);
    vecs[i].sel = s;        vecs[i].tData = td;     vecs[i].reply = rp;
    vecs[i].reStart = rs;   vecs[i].reData = rd2;   vecs[i].expBits = eb;
    vecs[i].expNBits = en;  vecs[i].expRdy = er;    vecs[i].expRd = erd;
    vecs[i].maxCycles = mc;
  endtask

  // Starts one transaction, then watches it cycle by cycle at the falling CLK edge,
  // collecting launched bits at MDC rises and playing the PHY once the line is released.
  task automatic applyStimulus(input vec_t v, input int resetBit);
    int   lastRise;
    int   phyIdx;
    logic phyActive, seenBusy, prevMdc, prevOe;
    @(negedge clk);
    sel    = v.sel;
    tDataR = v.tData;
    mdioIn = 1'b0;
    startR = 1'b1;
    @(negedge clk);
    startR = 1'b0;
    frameBits = '0; nBits = 0; oeCycles = 0; busyCycles = 0; rdyPulses = 0;
    outHigh = 0; mdcPeriod = 0; postBusy = 0; timedOut = 1'b1; resetHit = 1'b0;
    lastRise = -1; phyIdx = -1; phyActive = 1'b0; seenBusy = 1'b0;
    prevMdc = mdcW; prevOe = oeW;
    for (int cyc = 0; cyc < v.maxCycles; cyc++) begin
      if (busyW) busyCycles++;
      if (oeW) oeCycles++;
      if (rdyW) rdyPulses++;
      if (outW) outHigh++;
      if (!prevMdc && mdcW) begin
        if (lastRise >= 0) mdcPeriod = cyc - lastRise;
        lastRise = cyc;
        if (oeW) begin
          frameBits = {frameBits[62:0], outW};
          nBits++;
        end
      end
      if (prevOe && !oeW && busyW) begin
        mdioIn    = v.reply[15];
        phyIdx    = 14;
        phyActive = 1'b1;
      end else if (phyActive && prevMdc && !mdcW) begin
        if (phyIdx >= 0) begin
          mdioIn = v.reply[phyIdx];
          phyIdx--;
        end else begin
          phyActive = 1'b0;
        end
      end
      if (cyc == v.reStart) begin
        tDataR = v.reData;
        startR = 1'b1;
      end else if (cyc == v.reStart + 1) begin
        startR = 1'b0;
      end
      if (resetBit >= 0 && nBits == resetBit) begin
        rst_n = 1'b0;
        #1;
        snap     = {mdcW, oeW, outW, busyW, rdyW, rdDataW};
        resetHit = 1'b1;
        break;
      end
      if (busyW) begin
        seenBusy = 1'b1;
      end else if (seenBusy) begin
        timedOut = 1'b0;
        break;
      end
      prevMdc = mdcW;
      prevOe  = oeW;
      @(negedge clk);
    end
    startR = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rdyW) rdyPulses++;
      if (busyW) postBusy++;
    end
    rdDataEnd = rdDataW;
  endtask

  initial begin
    int   div;
    int   tail;
    vec_t rv;
    checks = 0; failures = 0;
    sel = 1'b0; startR = 1'b0; tDataR = '0; mdioIn = 1'b0; rst_n = 1'b0;
    #1;
    checkOutput("reset_dut0", {bus0.mdc, bus0.mdio_oe, bus0.mdio_out, bus0.busy, bus0.data_rdy, bus0.rd_data}, '0);
    checkOutput("reset_dut1", {bus1.mdc, bus1.mdio_oe, bus1.mdio_out, bus1.busy, bus1.data_rdy, bus1.rd_data}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    //       i  sel  tData         reply    rs  reData        expBits                 n   rdy expRd    max
    setVec(0, 1'b0, 32'h51AABEEF, 16'h0000, -1, 32'h0,        64'h51AABEEF,           32, 0, 16'h0000, 200);
    setVec(1, 1'b0, 32'h61AA0000, 16'hC3A5, -1, 32'h0,        64'h61AA,               16, 1, 16'hC3A5, 200);
    setVec(2, 1'b0, 32'h71AA0000, 16'h0000, -1, 32'h0,        64'h0,                  0,  0, 16'hC3A5, 20);
    setVec(3, 1'b0, 32'h11AABEEF, 16'h0000, -1, 32'h0,        64'h0,                  0,  0, 16'hC3A5, 20);
    setVec(4, 1'b0, 32'h51AABEEF, 16'h0000, 10, 32'h61AA0000, 64'h51AABEEF,           32, 0, 16'hC3A5, 200);
    setVec(5, 1'b0, 32'h6F5E0000, 16'h1234, -1, 32'h0,        64'h6F5E,               16, 1, 16'h1234, 200);
    setVec(6, 1'b0, 32'h5FFF0001, 16'h0000, -1, 32'h0,        64'h5FFF0001,           32, 0, 16'h1234, 200);
    setVec(7, 1'b1, 32'h61AA0000, 16'hFFFF, -1, 32'h0,        64'h0000FFFFFFFF61AA,   48, 1, 16'hFFFF, 800);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], -1);
      div = vecs[i].sel ? 4 : 1;
      checkOutput($sformatf("v%0d_bits", i), frameBits, vecs[i].expBits);
      checkOutput($sformatf("v%0d_nbits", i), 64'(nBits), 64'(vecs[i].expNBits));
      checkOutput($sformatf("v%0d_oe_cycles", i), 64'(oeCycles), 64'(vecs[i].expNBits * 2 * div));
      checkOutput($sformatf("v%0d_rdy_pulses", i), 64'(rdyPulses), 64'(vecs[i].expRdy));
      checkOutput($sformatf("v%0d_rd_data", i), 64'(rdDataEnd), 64'(vecs[i].expRd));
      checkOutput($sformatf("v%0d_post_busy", i), 64'(postBusy), 64'd0);
      if (vecs[i].expNBits > 0) begin
        tail = busyCycles - oeCycles - ((vecs[i].expRdy != 0) ? (32 * div - div) : 0);
        checkOutput($sformatf("v%0d_timeout", i), 64'(timedOut), 64'd0);
        checkOutput($sformatf("v%0d_busy_tail", i), 64'(tail >= 1 && tail <= 2 * div), 64'd1);
        checkOutput($sformatf("v%0d_mdc_period", i), 64'(mdcPeriod), 64'(2 * div));
      end else begin
        checkOutput($sformatf("v%0d_busy_cycles", i), 64'(busyCycles), 64'd0);
        checkOutput($sformatf("v%0d_out_high", i), 64'(outHigh), 64'd0);
      end
    end

    // Reset mid-read: outputs must clear at once, including the previously captured RD_DATA
    rv = vecs[1];
    rv.reply = 16'h0F0F;
    applyStimulus(rv, 10);
    checkOutput("rst_reached_bit10", 64'(resetHit), 64'd1);
    checkOutput("rst_outputs_zero", 64'(snap), 64'd0);
    checkOutput("rst_no_rdy", 64'(rdyPulses), 64'd0);
    checkOutput("rst_rd_data", 64'(rdDataEnd), 64'd0);
    rst_n = 1'b1;
    rv = vecs[0];
    applyStimulus(rv, -1);
    checkOutput("after_rst_bits", frameBits, 64'h51AABEEF);
    checkOutput("after_rst_nbits", 64'(nBits), 64'd32);
    checkOutput("after_rst_timeout", 64'(timedOut), 64'd0);
    checkOutput("after_rst_rdy", 64'(rdyPulses), 64'd0);
    checkOutput("after_rst_rd_data", 64'(rdDataEnd), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
